// File: rtl/fifo_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter_if
// Bundles the requester-side and FIFO-side handshake of fifo_rr_arbiter.
//   req_valid  [NREQ]      per-requester beat valid
//   req_data   [NREQ*DW]   requester i at [i*DW +: DW], bit DW-1 = last
//   req_ready  [NREQ]      per-requester accept
//   out_valid / out_data / out_id   registered beat towards the FIFO
//   out_ready              FIFO upstream ready
//   locked                 a packet is in progress, grant held
// Modports: slave = arbiter side, master = requesters/FIFO side.
// -----------------------------------------------------------------------------
interface fifo_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 33,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               out_ready;
  logic               locked;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, locked
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, locked
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter
// Packet-aware round-robin N-to-1 arbiter feeding the upstream port of the
// 33-bit synchronous FIFO through a one-deep registered output stage.
// Ports:
//   clk   clock, rising edge
//   nrst  asynchronous active-low reset
//   arb   fifo_rr_arbiter_if.slave (requester handshakes, FIFO handshake,
//         locked status)
// -----------------------------------------------------------------------------
module fifo_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 33,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              nrst,
  fifo_rr_arbiter_if.slave  arb
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_out_valid;
  logic [DW-1:0]  r_out_data;
  logic [IDW-1:0] r_out_id;

  logic [DW-1:0]   w_beat [NREQ];
  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_ready;
  logic [IDW-1:0]  w_gnt_idx;
  logic [DW-1:0]   w_sel_beat;
  logic            w_load_en;
  logic            w_xfer;
  logic            w_last;

  // Unpack the flat requester data bus into one beat per requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_beat[gi] = arb.req_data[gi*DW +: DW];
    end
  endgenerate

  // The output stage can take a beat when empty or draining this cycle.
  assign w_load_en = !r_out_valid | arb.out_ready;

  // Grant selection. While locked only the owner may be granted. While
  // unlocked the scan runs from the farthest offset down to offset 0 so the
  // requester nearest rr_ptr is the last to be assigned and therefore wins.
  always_comb begin : p_grant
    int             idx;
    logic [IDW-1:0] idx_w;
    w_gnt     = '0;
    w_gnt_idx = r_owner;
    idx       = 0;
    idx_w     = '0;
    if (r_state == ST_LOCKED) begin
      w_gnt[r_owner] = arb.req_valid[r_owner];
    end else begin
      for (int off = NREQ - 1; off >= 0; off--) begin
        idx = int'(r_rr_ptr) + off;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end
        idx_w = IDW'(idx);
        if (arb.req_valid[idx_w]) begin
          w_gnt        = '0;
          w_gnt[idx_w] = 1'b1;
          w_gnt_idx    = idx_w;
        end
      end
    end
  end

  // A grant bit is only ever set for a valid requester, so any ready bit
  // implies a transfer.
  assign w_ready       = nrst ? (w_gnt & {NREQ{w_load_en}}) : '0;
  assign arb.req_ready = w_ready;
  assign w_xfer        = |w_ready;
  assign w_sel_beat    = w_beat[w_gnt_idx];
  assign w_last        = w_sel_beat[DW-1];

  // Lock state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Lock next-state. A single-beat packet never enters LOCKED.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_UNLOCKED: if (w_xfer && !w_last) w_state_next = ST_LOCKED;
      ST_LOCKED:   if (w_xfer &&  w_last) w_state_next = ST_UNLOCKED;
      default:     w_state_next = ST_UNLOCKED;
    endcase
  end

  // Output register, owner and round-robin pointer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_beat;
        r_out_id    <= w_gnt_idx;
      end else if (arb.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_xfer && (r_state == ST_UNLOCKED) && !w_last) begin
        r_owner <= w_gnt_idx;
      end
      // Pointer wraps at NREQ, not at 2**IDW.
      if (w_xfer && w_last) begin
        r_rr_ptr <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  assign arb.out_valid = r_out_valid;
  assign arb.out_data  = r_out_data;
  assign arb.out_id    = r_out_id;
  assign arb.locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_arbiter
// Directed bench for fifo_rr_arbiter. Requester sources are per-index beat
// queues; every beat is also pushed to an expected-output scoreboard in the
// order the arbitration rules require, and popped when the beat shows up on
// the registered output one cycle after its transfer.
// -----------------------------------------------------------------------------
module tb_fifo_rr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 33;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

  fifo_rr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .arb  (bus)
  );

  int              vectors     = 0;
  int              miscompares = 0;
  int              seq_n       = 0;
  exp_t            exp_q[$];
  logic [DW-1:0]   src_q[NREQ][$];
  logic            lk_hist[$];
  logic [NREQ-1:0] fire = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int id, input bit last);
    seq_n++;
    return {last, 8'(id), 24'(seq_n)};
  endfunction

  // Queue nbeats for requester id (last on the final beat); the first nexp of
  // them are expected at the output in this order.
  task automatic send(input int id, input int nbeats, input int nexp);
    logic [DW-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = mk(id, b == nbeats - 1);
      src_q[id].push_back(d);
      if (b < nexp) exp_q.push_back('{id: IDW'(id), data: d});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic drain(input int maxc, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < maxc) begin
      step();
      cyc++;
    end
    chk("drain_empty", 64'(exp_q.size()), 0);
  endtask

  // Handshake capture, away from the active edge.
  always @(negedge clk) begin
    fire = bus.req_valid & bus.req_ready;
    if (fire != '0) lk_hist.push_back(bus.locked);
  end

  // Monitor + source driver, 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (fire != '0) begin
      chk("xfer_onehot", 64'($countones(fire)), 1);
      for (int i = 0; i < NREQ; i++)
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      chk("out_valid", 64'(bus.out_valid), 1);
      chk("out_id", 64'(bus.out_id), 64'(e.id));
      chk("out_data", 64'(bus.out_data), 64'(e.data));
    end
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = (src_q[i].size() > 0);
      bus.req_data[i*DW +: DW]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            cyc;
    logic [7:0]    h;
    logic [DW-1:0] held;

    nrst          = 1'b0;
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset with all requesters valid, then single-beat round robin.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) send(i, 1, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_locked", 64'(bus.locked), 0);
    chk("rst_out_id", 64'(bus.out_id), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    step();
    nrst = 1'b1;
    #1;
    chk("first_grant", 64'(bus.req_ready), 64'(4'b0001));
    drain(20, cyc);
    chk("rr_cycles", 64'(cyc), 8);

    // Packet lock: requester 1 three beats, requester 2 waiting.
    lk_hist.delete();
    send(1, 3, 3);
    send(2, 1, 1);
    drain(20, cyc);
    chk("lock_cycles", 64'(cyc), 5);
    h = '0;
    foreach (lk_hist[k]) h = {h[6:0], lk_hist[k]};
    chk("lock_hist_len", 64'(lk_hist.size()), 4);
    chk("lock_hist", 64'(h), 64'(8'b0110));

    // Backpressure mid-packet.
    send(0, 4, 4);
    send(1, 1, 1);
    held = src_q[0][0];
    step();
    step();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(bus.req_ready), 0);
      chk("bp_locked", 64'(bus.locked), 1);
      chk("bp_out_valid", 64'(bus.out_valid), 1);
      chk("bp_out_data", 64'(bus.out_data), 64'(held));
    end
    bus.out_ready = 1'b1;
    drain(20, cyc);

    // Owner stall: requester 3 locks, then goes idle while 0..2 wait.
    lk_hist.delete();
    send(3, 1, 0);
    exp_q.push_back('{id: IDW'(3), data: src_q[3][0] & ~(33'd1 << 32)});
    src_q[3][0] = src_q[3][0] & ~(33'd1 << 32);
    step();
    step();
    chk("stall_locked_on", 64'(bus.locked), 1);
    held = mk(3, 1'b1);
    exp_q.push_back('{id: IDW'(3), data: held});
    for (int i = 0; i < 3; i++) send(i, 1, 1);
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_req_ready", 64'(bus.req_ready), 0);
      chk("stall_locked", 64'(bus.locked), 1);
      chk("stall_out_valid", 64'(bus.out_valid), 0);
    end
    src_q[3].push_back(held);
    drain(20, cyc);
    h = '0;
    foreach (lk_hist[k]) h = {h[6:0], lk_hist[k]};
    chk("stall_hist_len", 64'(lk_hist.size()), 5);
    chk("stall_hist", 64'(h), 64'(8'b01000));

    // Reset in the middle of a locked packet.
    send(2, 4, 2);
    step();
    step();
    step();
    chk("mid_locked", 64'(bus.locked), 1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_locked", 64'(bus.locked), 0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 0);
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    step();
    step();
    for (int i = 0; i < NREQ; i++) send(i, 1, 1);
    step();
    nrst = 1'b1;
    #1;
    chk("restart_grant", 64'(bus.req_ready), 64'(4'b0001));
    drain(20, cyc);
    chk("restart_cycles", 64'(cyc), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
